// File: rtl/pla_squar5_sum_accumulator.sv
// pla_squar5_sum_accumulator
// Sums up to BLOCK_LEN consecutive squares from the 5-bit squaring PLA.
// A block ends early when an accepted beat carries in_last.
// The block result (sum, beat count, overflow) is held on a registered
// valid/ready output until downstream takes it.
module pla_squar5_sum_accumulator #(
    parameter  int DATA_W    = 8,
    parameter  int ACC_W     = 16,
    parameter  int BLOCK_LEN = 16,
    parameter  int SATURATE  = 1,
    localparam int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_accept;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_close;

    // in_ready comes from the state register only, never from out_ready
    assign in_ready  = (r_state == ACCUM);
    assign w_accept  = in_valid & in_ready;

    // One extra bit on the sum catches the carry out of the accumulator
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign w_ovf_nxt = w_sum[ACC_W] | r_ovf;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_close   = in_last | (w_cnt_nxt == CNT_W'(BLOCK_LEN));

    // Next accumulator value: pinned at all-ones once saturated, else wrap
    always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_ovf_nxt && (SATURATE != 0)) begin
            w_acc_nxt = '1;
        end
    end

    // Two-state block FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_close) begin
                            // Publish the post-update block values and start fresh
                            r_out_sum   <= w_acc_nxt;
                            r_out_count <= w_cnt_nxt;
                            r_out_ovf   <= w_ovf_nxt;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_ovf       <= 1'b0;
                            r_state     <= HOLD;
                        end else begin
                            r_acc <= w_acc_nxt;
                            r_cnt <= w_cnt_nxt;
                            r_ovf <= w_ovf_nxt;
                        end
                    end
                end
                HOLD: begin
                    // Result fields keep their values after the handshake
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_pla_squar5_sum_accumulator.sv
// Directed bench for pla_squar5_sum_accumulator. A default instance plus two
// ACC_W=11 instances (saturating and wrapping) share the same stimulus; the
// control path does not depend on ACC_W, so all three stay in lockstep.
module tb_pla_squar5_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf;
    logic [15:0] out_sum;
    logic [4:0]  out_count;

    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [10:0] s_out_sum;
    logic [4:0]  s_out_count;

    logic        w_in_ready, w_out_valid, w_out_ovf;
    logic [10:0] w_out_sum;
    logic [4:0]  w_out_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pla_squar5_sum_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_ovf(out_ovf)
    );

    pla_squar5_sum_accumulator #(.ACC_W(11), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count),
        .out_ovf(s_out_ovf)
    );

    pla_squar5_sum_accumulator #(.ACC_W(11), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_sum(w_out_sum), .out_count(w_out_count),
        .out_ovf(w_out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single edge, then drop in_valid
    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int sum, input int cnt, input int ovf);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(out_sum),   32'(sum));
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
        chk({tag, "_rdy0"},  32'(in_ready),  32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 8'd225; in_last = 1'b0; out_ready = 1'b1;

        // Reset for two edges with in_valid high: nothing accumulates
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_rdy",   32'(in_ready),  32'd1);
        chk("rst_valid2",32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf",   32'(out_ovf),   32'd0);

        // 16 beats of 225 back-to-back, downstream always ready
        in_valid = 1'b1; in_data = 8'd225; in_last = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        in_valid = 1'b0;
        chk_result("full", 3600, 16, 0);
        chk("sat_sum",  32'(s_out_sum), 32'd2047);
        chk("sat_ovf",  32'(s_out_ovf), 32'd1);
        chk("wrap_sum", 32'(w_out_sum), 32'd1552);
        chk("wrap_ovf", 32'(w_out_ovf), 32'd1);
        chk("sat_cnt",  32'(s_out_count), 32'd16);
        tick();
        chk("full_rdy1",   32'(in_ready),  32'd1);
        chk("full_valid0", 32'(out_valid), 32'd0);

        // Early close with in_last on the third beat
        beat(8'd1, 1'b0);
        beat(8'd4, 1'b0);
        beat(8'd9, 1'b1);
        chk_result("last3", 14, 3, 0);
        tick();
        // Next block starts from zero; in_last on the first beat -> 1-beat block
        beat(8'd4, 1'b1);
        chk_result("one", 4, 1, 0);
        tick();

        // Backpressure: result must hold and no beats may be consumed
        out_ready = 1'b0;
        beat(8'd9, 1'b0);
        beat(8'd16, 1'b1);
        chk_result("bp", 25, 2, 0);
        in_valid = 1'b1; in_data = 8'd100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_result($sformatf("bp_hold%0d", i), 25, 2, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_rdy1",   32'(in_ready),  32'd1);
        chk("bp_valid0", 32'(out_valid), 32'd0);
        beat(8'd1, 1'b1);
        chk_result("bp_after", 1, 1, 0);
        tick();

        // in_last coinciding with the 16th beat closes exactly one block
        in_valid = 1'b1; in_data = 8'd2; in_last = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk_result("both", 32, 16, 0);
        tick();
        tick();
        chk("both_noextra", 32'(out_valid), 32'd0);

        // Reset mid-block discards the partial sum
        for (int i = 0; i < 7; i++) beat(8'd100, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        beat(8'd50, 1'b0);
        beat(8'd50, 1'b1);
        chk_result("mid_rst", 100, 2, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
